// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the scoreboarded register file
//
// Purpose: state encoding, default geometry and depth derivation used by
//          register_file_sb and regfile_scoreboard.
// Ports:   none (package).
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Scrub runs first after every reset; READY is terminal until the next reset.
    typedef enum logic [0:0] {
        SCRUB = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits with busy lookups
//
// Purpose: one pending bit per register. Issue sets a bit, writeback clears
//          it; when both hit the same register in one cycle the set wins
//          because the issuing instruction is the newer producer.
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   set_en, set_addr        mark a register as having an outstanding producer
//   clr_en, clr_addr        writeback retires the producer of a register
//   lk_addr                 NUM_RD packed lookup addresses
//   busy                    NUM_RD pending flags, masked by a same-cycle clear
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] lk_addr,
    output logic [NUM_RD-1:0]        busy
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr_en) begin
            pend_d[clr_addr] = 1'b0;
        end
        // Applied after the clear so a same-register issue overrides it.
        if (set_en) begin
            pend_d[set_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_lookup
        logic [ADDR_W-1:0] addr;
        assign addr = lk_addr[p*ADDR_W +: ADDR_W];
        // A writeback landing this cycle already supplies the value via bypass.
        assign busy[p] = pend_q[addr] & ~(clr_en & (clr_addr == addr));
    end

endmodule

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - register file with write bypass, scoreboard and reset scrub
//
// Purpose: NUM_RD combinational read ports with same-cycle write bypass,
//          optional hardwired zero register, pending scoreboard for hazard
//          detection, and a scrub sequencer that zeroes every entry after
//          reset before raising ready.
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   rd_addr / rd_data       packed read addresses / read data, port i at slice i
//   rd_busy                 port i's register has an outstanding producer
//   w_en, w_addr, w_data    writeback
//   iss_en, iss_addr        decode issue of a destination register
//   ready                   scrub complete, writes and issues accepted
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     w_en,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     ready
);

    localparam int DEPTH = depth_of(ADDR_W);

    localparam logic [0:0] S_SCRUB = SCRUB;
    localparam logic [0:0] S_READY = READY;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [ADDR_W-1:0] scrub_cnt_q;
    logic [ADDR_W-1:0] scrub_cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic is_ready;
    logic w_zero;
    logic iss_zero;
    logic wr_ok;
    logic iss_ok;
    logic clr_ok;
    logic [NUM_RD-1:0] sb_busy;

    assign is_ready = (state_q == S_READY);
    assign ready    = is_ready;

    assign w_zero   = (ZERO_REG != 0) && (w_addr == '0);
    assign iss_zero = (ZERO_REG != 0) && (iss_addr == '0);

    // Writeback and issue are ignored while scrubbing.
    assign wr_ok  = is_ready & w_en & ~w_zero;
    assign iss_ok = is_ready & iss_en & ~iss_zero;
    assign clr_ok = is_ready & w_en;

    always_comb begin
        state_d     = state_q;
        scrub_cnt_d = scrub_cnt_q;
        if (state_q == S_SCRUB) begin
            scrub_cnt_d = scrub_cnt_q + 1'b1;
            if (scrub_cnt_q == LAST_ADDR) begin
                state_d = S_READY;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_SCRUB;
            scrub_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            scrub_cnt_q <= scrub_cnt_d;
        end
    end

    // Storage is not reset; the scrub sequence clears it instead. While reset
    // is held the counter sits at 0, so only entry 0 is repeatedly zeroed.
    always_ff @(posedge clock) begin
        if (!is_ready) begin
            mem_q[scrub_cnt_q] <= '0;
        end else if (wr_ok) begin
            mem_q[w_addr] <= w_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock    (clock),
        .reset_n  (reset_n),
        .set_en   (iss_ok),
        .set_addr (iss_addr),
        .clr_en   (clr_ok),
        .clr_addr (w_addr),
        .lk_addr  (rd_addr),
        .busy     (sb_busy)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];
        assign hit  = w_en && (w_addr == addr);

        always_comb begin
            data = '0;
            if (!is_ready) begin
                data = '0;
            end else if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
            end else if (hit) begin
                data = w_data;
            end else begin
                data = mem_q[addr];
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data;
        assign rd_busy[p] = is_ready & sb_busy[p];
    end

endmodule
